ps2_key_sequencer: RTL and testbench
====================================

# ps2_key_sequencer

Sequences the PS/2 receiver FIFO and turns its raw scan-code byte stream into decoded key events. It drives the receiver's read acknowledge and tracks E0 (extended) and F0 (break) prefixes. It keeps the make-key counter and current-held-key status, and buffers complete events for the ASCII/display consumer. It sits between `ps2_keyboard` (byte source) and the scancode-to-ASCII lookup and text logic (event sink).

## Interface
- `FIFO_DEPTH`, default 4: event buffer entries; power of two, minimum 2.
- `clk`  in  1  system clock.
- `clr`  in  1  reset; synchronous and active-high.
- `ps2_data`  in  8  head byte of the receiver FIFO.
- `ps2_ready`  in  1  receiver FIFO non-empty.
- `ps2_overflow`  in  1  receiver FIFO overflow flag.
- `ps2_nextdata_n`  out  1  active-low read acknowledge; exactly one cycle low per byte consumed.
- `ev_valid`  out  1  event available at the buffer head.
- `ev_ready`  in  1  consumer accepts the head event.
- `ev_code`  out  8  scan code of the head event, with prefixes stripped.
- `ev_ext`  out  1  head event was E0-prefixed.
- `ev_break`  out  1  head event is a release (F0-prefixed).
- `key_count`  out  8  number of make events accepted.
- `cur_key`  out  8  code of the key currently held; 0 when none.
- `ovf_seen`  out  1  sticky flag: `ps2_overflow` has been observed high.

## Operation
- FSM states: IDLE, ACK, SETTLE.
  - IDLE→ACK when `ps2_ready` && !`ps2_overflow` && buffer not full. The byte is latched into `byte_q` on that edge.
  - ACK→SETTLE unconditionally. `ps2_nextdata_n` is 0 only in ACK, driven directly from the state register. The latched byte is decoded during ACK.
  - SETTLE→IDLE unconditionally. This cycle gives the receiver time to update `ps2_ready`.
- Decode of `byte_q` in ACK:
  - 0xE0: set `ext_pend`. No event.
  - 0xF0: set `brk_pend`. No event.
  - Any other value: push {`ext_pend`, `brk_pend`, code} into the buffer, then clear both pending flags.
- Status updates on a pushed event:
  - Make: `key_count` increments, wrapping 255→0. `cur_key` ← code.
  - Break: if code == `cur_key`, `cur_key` ← 0. Otherwise `cur_key` is unchanged.
- Buffer:
  - Pop when `ev_valid && ev_ready`.
  - Push and pop may occur in the same cycle. Occupancy is then unchanged.
  - Full is evaluated in IDLE only; a pop in that same cycle does not allow the fetch. A push therefore can never overflow the buffer.
- Overflow:
  - While `ps2_overflow` is high, no fetch occurs and the FSM holds in IDLE.
  - `ovf_seen` is set and stays set until `clr`.
  - Pending prefix flags are kept.
- Reset values: FSM in IDLE, `ps2_nextdata_n`=1, `ev_valid`=0, `ev_code`/`ev_ext`/`ev_break`=0, `key_count`=0, `cur_key`=0, `ovf_seen`=0, buffer empty, pending flags clear.
- Reset during ACK: the acknowledge stops in that cycle and the latched byte is discarded. Already-acknowledged bytes are not replayed.

## Timing
- Throughput is one receiver byte per 3 cycles.
- Edge N: IDLE sees the fetch condition. Cycle N+1: ACK, `ps2_nextdata_n`=0, push. Cycle N+2: `ev_valid`=1 (if the buffer was empty), SETTLE. Cycle N+3: IDLE.
- Latency from `ps2_ready` to `ev_valid` is 2 cycles.
- `key_count` and `cur_key` update on the same edge as the push.
- Outputs `ev_*` are registered head-of-buffer values, stable while `ev_valid && !ev_ready`.

## Configuration
- `KEY_REPEAT_FILTER_EN` defined:
  - A make whose {ext, code} equals the held key is a typematic repeat. It is dropped: no push, no `key_count` change.
  - The held ext bit is tracked alongside `cur_key`.
- `KEY_REPEAT_FILTER_EN` undefined: every make is pushed and counted.

## Structure
- Shared package `ps2_pkg`:
  - constants `SC_EXT`=8'hE0 and `SC_BRK`=8'hF0;
  - FSM state enum;
  - packed event struct {ext, brk, code[7:0]}.
- Sub-module `key_event_fifo`: synchronous FIFO of width 10 and depth `FIFO_DEPTH`, with push/pop/full/empty and registered head outputs.

## Test plan
- Bytes 1C, F0, 1C (each with `ev_ready`=1) → events {0,0,1C} then {0,1,1C}; `key_count`=1; `cur_key`=1C then 0; exactly 3 single-cycle `ps2_nextdata_n` pulses.
- Bytes E0, 75, E0, F0, 75 → events {1,0,75} and {1,1,75}; `key_count`=1.
- `ev_ready`=0 with 5 make codes and `FIFO_DEPTH`=4 → 4 events buffered; 5th byte not acknowledged until one pop; then all 5 delivered in order.
- `ps2_overflow`=1 while `ps2_ready`=1 for 10 cycles → `ps2_nextdata_n` stays 1; `ovf_seen`=1 and held after overflow clears; fetch resumes afterwards.
- With `KEY_REPEAT_FILTER_EN`: bytes 1C, 1C, 1C, F0, 1C → 2 events; `key_count`=1. Without it: 4 events, `key_count`=3.
- `clr` asserted in the ACK cycle of byte 2D, after 255 prior makes → next cycle all outputs at reset values; next make gives `key_count`=1 (wrap also checked separately: 256 makes → 0).

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared scan-code constants, sequencer state encoding and key event payload.
package ps2_pkg;

   localparam logic [7:0]  SC_EXT = 8'hE0;
   localparam logic [7:0]  SC_BRK = 8'hF0;
   localparam int unsigned EV_W   = 10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACK    = 2'd1,
      ST_SETTLE = 2'd2
   } seq_state_e;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } key_event_t;

endpackage

// File: rtl/key_event_fifo.sv
// Synchronous key event FIFO with registered head-of-queue outputs.
module key_event_fifo
   import ps2_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       push_i,
   input  key_event_t push_data_i,
   input  logic       pop_i,
   output logic       full_o,
   output logic       empty_o,
   output logic       head_valid_o,
   output key_event_t head_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   key_event_t       mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d;
   logic [PTR_W-1:0] rd_q, rd_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] occ_after_pop;
   logic             head_valid_q, head_valid_d;
   key_event_t       head_q, head_d;
   logic             push_ok, pop_ok;

   assign full_o       = (count_q == CNT_W'(DEPTH));
   assign empty_o      = (count_q == '0);
   assign head_valid_o = head_valid_q;
   assign head_o       = head_q;

   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   // New head is the next stored entry, or the incoming push if nothing else remains.
   always_comb begin
      wr_d          = wr_q;
      rd_d          = rd_q;
      head_d        = head_q;
      occ_after_pop = count_q - CNT_W'(pop_ok);
      count_d       = occ_after_pop + CNT_W'(push_ok);
      if (push_ok) wr_d = wr_q + PTR_W'(1);
      if (pop_ok)  rd_d = rd_q + PTR_W'(1);
      if (occ_after_pop != '0) begin
         head_d = mem_q[rd_d];
      end else if (push_ok) begin
         head_d = push_data_i;
      end
      head_valid_d = (count_d != '0);
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         wr_q         <= '0;
         rd_q         <= '0;
         count_q      <= '0;
         head_valid_q <= 1'b0;
         head_q       <= '0;
      end else begin
         wr_q         <= wr_d;
         rd_q         <= rd_d;
         count_q      <= count_d;
         head_valid_q <= head_valid_d;
         head_q       <= head_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q] <= push_data_i;
   end

endmodule

// File: rtl/ps2_key_sequencer.sv
// Fetches PS/2 receiver bytes, decodes E0/F0 prefixes into key events and keeps key status.
// Optional KEY_REPEAT_FILTER_EN drops typematic repeats of the held key.
module ps2_key_sequencer
   import ps2_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       clr,
   input  logic [7:0] ps2_data,
   input  logic       ps2_ready,
   input  logic       ps2_overflow,
   output logic       ps2_nextdata_n,
   output logic       ev_valid,
   input  logic       ev_ready,
   output logic [7:0] ev_code,
   output logic       ev_ext,
   output logic       ev_break,
   output logic [7:0] key_count,
   output logic [7:0] cur_key,
   output logic       ovf_seen
);

   seq_state_e state_q, state_d;
   logic [7:0] byte_q, byte_d;
   logic       ext_pend_q, ext_pend_d;
   logic       brk_pend_q, brk_pend_d;
   logic [7:0] key_count_q, key_count_d;
   logic [7:0] cur_key_q, cur_key_d;
   logic       ovf_seen_q, ovf_seen_d;
   logic       nextdata_n_q;
`ifdef KEY_REPEAT_FILTER_EN
   logic       cur_ext_q, cur_ext_d;
`endif

   logic       push_c;
   key_event_t push_ev_c;
   logic       pop_c;
   logic       fifo_full, fifo_empty;
   key_event_t head;

   assign pop_c = ev_ready && !fifo_empty;

   always_comb begin
      state_d     = state_q;
      byte_d      = byte_q;
      ext_pend_d  = ext_pend_q;
      brk_pend_d  = brk_pend_q;
      key_count_d = key_count_q;
      cur_key_d   = cur_key_q;
`ifdef KEY_REPEAT_FILTER_EN
      cur_ext_d   = cur_ext_q;
`endif
      ovf_seen_d  = ovf_seen_q | ps2_overflow;
      push_c      = 1'b0;
      push_ev_c   = '{ext: ext_pend_q, brk: brk_pend_q, code: byte_q};

      unique case (state_q)
         ST_IDLE: begin
            // Full is judged here only, so a push in ACK always has room.
            if (ps2_ready && !ps2_overflow && !fifo_full) begin
               state_d = ST_ACK;
               byte_d  = ps2_data;
            end
         end
         ST_ACK: begin
            state_d = ST_SETTLE;
            if (byte_q == SC_EXT) begin
               ext_pend_d = 1'b1;
            end else if (byte_q == SC_BRK) begin
               brk_pend_d = 1'b1;
            end else begin
               ext_pend_d = 1'b0;
               brk_pend_d = 1'b0;
               if (brk_pend_q) begin
                  push_c = 1'b1;
                  if (byte_q == cur_key_q) begin
                     cur_key_d = '0;
`ifdef KEY_REPEAT_FILTER_EN
                     cur_ext_d = 1'b0;
`endif
                  end
               end else begin
`ifdef KEY_REPEAT_FILTER_EN
                  if (!((cur_key_q != '0) && (cur_key_q == byte_q) && (cur_ext_q == ext_pend_q))) begin
                     push_c      = 1'b1;
                     key_count_d = key_count_q + 8'd1;
                     cur_key_d   = byte_q;
                     cur_ext_d   = ext_pend_q;
                  end
`else
                  push_c      = 1'b1;
                  key_count_d = key_count_q + 8'd1;
                  cur_key_d   = byte_q;
`endif
               end
            end
         end
         ST_SETTLE: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q      <= ST_IDLE;
         byte_q       <= '0;
         ext_pend_q   <= 1'b0;
         brk_pend_q   <= 1'b0;
         key_count_q  <= '0;
         cur_key_q    <= '0;
         ovf_seen_q   <= 1'b0;
         nextdata_n_q <= 1'b1;
`ifdef KEY_REPEAT_FILTER_EN
         cur_ext_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         byte_q       <= byte_d;
         ext_pend_q   <= ext_pend_d;
         brk_pend_q   <= brk_pend_d;
         key_count_q  <= key_count_d;
         cur_key_q    <= cur_key_d;
         ovf_seen_q   <= ovf_seen_d;
         nextdata_n_q <= (state_d != ST_ACK);
`ifdef KEY_REPEAT_FILTER_EN
         cur_ext_q    <= cur_ext_d;
`endif
      end
   end

   key_event_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk          (clk),
      .clr          (clr),
      .push_i       (push_c),
      .push_data_i  (push_ev_c),
      .pop_i        (pop_c),
      .full_o       (fifo_full),
      .empty_o      (fifo_empty),
      .head_valid_o (ev_valid),
      .head_o       (head)
   );

   assign ps2_nextdata_n = nextdata_n_q;
   assign ev_code        = head.code;
   assign ev_ext         = head.ext;
   assign ev_break       = head.brk;
   assign key_count      = key_count_q;
   assign cur_key        = cur_key_q;
   assign ovf_seen       = ovf_seen_q;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Bench for ps2_key_sequencer: receiver-FIFO model, event-level reference model, directed and random traffic.
`timescale 1ns/1ps
module tb_ps2_key_sequencer;

   localparam int unsigned DEPTH = 4;
`ifdef KEY_REPEAT_FILTER_EN
   localparam bit FILTER_EN = 1'b1;
`else
   localparam bit FILTER_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic [7:0] ps2_data = 8'h00;
   logic       ps2_ready = 1'b0;
   logic       ps2_overflow = 1'b0;
   logic       ps2_nextdata_n;
   logic       ev_valid;
   logic       ev_ready = 1'b0;
   logic [7:0] ev_code;
   logic       ev_ext;
   logic       ev_break;
   logic [7:0] key_count;
   logic [7:0] cur_key;
   logic       ovf_seen;

   always #5 clk = ~clk;

   ps2_key_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
      .clk            (clk),
      .clr            (clr),
      .ps2_data       (ps2_data),
      .ps2_ready      (ps2_ready),
      .ps2_overflow   (ps2_overflow),
      .ps2_nextdata_n (ps2_nextdata_n),
      .ev_valid       (ev_valid),
      .ev_ready       (ev_ready),
      .ev_code        (ev_code),
      .ev_ext         (ev_ext),
      .ev_break       (ev_break),
      .key_count      (key_count),
      .cur_key        (cur_key),
      .ovf_seen       (ovf_seen)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Receiver byte source and reference model state
   logic [7:0] src_q[$];
   logic [9:0] mq[$];
   logic [9:0] log_q[$];
   logic [7:0] m_count;
   logic [7:0] m_cur;
   logic       m_cur_ext;
   logic       m_ext_p, m_brk_p, m_ovf;
   bit         model_on = 1'b0;
   int         acks = 0;
   int         rdy_mode = 0;
   int         prev_size = 0;
   logic       prev_ovf = 1'b0;
   logic       prev_nd = 1'b1, prev2_nd = 1'b1;

   // Per-cycle compare, then advance the model by what the coming edge will do.
   always @(negedge clk) begin
      int         cur_size;
      logic [7:0] b;
      bit         popping, acking, rep;
      cur_size = mq.size();
      if (model_on) begin
         chk("ev_valid", 32'(ev_valid), 32'(cur_size != 0));
         if (cur_size != 0) chk("ev_head", 32'({ev_ext, ev_break, ev_code}), 32'(mq[0]));
         chk("key_count", 32'(key_count), 32'(m_count));
         chk("cur_key", 32'(cur_key), 32'(m_cur));
         chk("ovf_seen", 32'(ovf_seen), 32'(m_ovf));
         if (!ps2_nextdata_n) begin
            chk("ack_src_nonempty", 32'(src_q.size() != 0), 32'd1);
            chk("ack_not_full", 32'(prev_size < int'(DEPTH)), 32'd1);
            chk("ack_no_ovf", 32'(prev_ovf), 32'd0);
            chk("ack_spacing", 32'({prev_nd, prev2_nd}), 32'd3);
         end
      end
      case (rdy_mode)
         0:       ev_ready = 1'b1;
         1:       ev_ready = 1'b0;
         default: ev_ready = 1'($urandom_range(0, 2) != 0);
      endcase
      popping = (cur_size != 0) && ev_ready;
      acking  = !ps2_nextdata_n;
      b       = 8'h00;
      if (acking) begin
         acks++;
         if (src_q.size() != 0) b = src_q.pop_front();
      end
      if (clr) begin
         mq.delete();
         m_count = 8'd0; m_cur = 8'd0; m_cur_ext = 1'b0;
         m_ext_p = 1'b0; m_brk_p = 1'b0; m_ovf = 1'b0;
         model_on = 1'b1;
      end else if (model_on) begin
         if (popping) begin
            log_q.push_back({ev_ext, ev_break, ev_code});
            void'(mq.pop_front());
         end
         if (acking) begin
            if (b == 8'hE0) m_ext_p = 1'b1;
            else if (b == 8'hF0) m_brk_p = 1'b1;
            else begin
               if (m_brk_p) begin
                  mq.push_back({m_ext_p, 1'b1, b});
                  if (b == m_cur) begin m_cur = 8'd0; m_cur_ext = 1'b0; end
               end else begin
                  rep = FILTER_EN && (m_cur != 8'd0) && (m_cur == b) && (m_cur_ext == m_ext_p);
                  if (!rep) begin
                     mq.push_back({m_ext_p, 1'b0, b});
                     m_count = m_count + 8'd1;
                     m_cur = b;
                     m_cur_ext = m_ext_p;
                  end
               end
               m_ext_p = 1'b0;
               m_brk_p = 1'b0;
            end
         end
         if (ps2_overflow) m_ovf = 1'b1;
      end
      ps2_ready = (src_q.size() != 0);
      ps2_data  = ps2_ready ? src_q[0] : 8'h00;
      prev2_nd  = prev_nd;
      prev_nd   = ps2_nextdata_n;
      prev_ovf  = ps2_overflow;
      prev_size = cur_size;
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1 clr = 1'b1;
      @(posedge clk); @(posedge clk); #1 clr = 1'b0;
      log_q.delete();
      acks = 0;
   endtask

   task automatic send(input logic [7:0] b);
      src_q.push_back(b);
   endtask

   task automatic drain(input int budget);
      bit done;
      done = 1'b0;
      rdy_mode = 0;
      for (int i = 0; i < budget; i++) begin
         cycles(1);
         if (src_q.size() == 0 && mq.size() == 0 && !ev_valid && ps2_nextdata_n) begin
            done = 1'b1;
            break;
         end
      end
      chk("drain_done", 32'(done), 32'd1);
      cycles(3);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_nextdata_n"}, 32'(ps2_nextdata_n), 32'd1);
      chk({tag, "_ev_valid"},   32'(ev_valid), 32'd0);
      chk({tag, "_ev_fields"},  32'({ev_ext, ev_break, ev_code}), 32'd0);
      chk({tag, "_key_count"},  32'(key_count), 32'd0);
      chk({tag, "_cur_key"},    32'(cur_key), 32'd0);
      chk({tag, "_ovf_seen"},   32'(ovf_seen), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] tbl [8];
      logic [7:0] mk5 [5];
      bit found;
      tbl = '{8'hE0, 8'hF0, 8'h1C, 8'h1B, 8'h75, 8'h2D, 8'h16, 8'h1C};
      mk5 = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};

      do_reset();
      chk_reset_outputs("reset");

      // make / break of 1C
      send(8'h1C); send(8'hF0); send(8'h1C);
      drain(100);
      chk("t1_events", 32'(log_q.size()), 32'd2);
      if (log_q.size() == 2) begin
         chk("t1_ev0", 32'(log_q[0]), 32'h01C);
         chk("t1_ev1", 32'(log_q[1]), 32'h11C);
      end
      chk("t1_key_count", 32'(key_count), 32'd1);
      chk("t1_cur_key", 32'(cur_key), 32'd0);
      chk("t1_acks", 32'(acks), 32'd3);

      // extended make / break
      do_reset();
      send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
      drain(100);
      chk("t2_events", 32'(log_q.size()), 32'd2);
      if (log_q.size() == 2) begin
         chk("t2_ev0", 32'(log_q[0]), 32'h275);
         chk("t2_ev1", 32'(log_q[1]), 32'h375);
      end
      chk("t2_key_count", 32'(key_count), 32'd1);

      // backpressure: buffer fills, fifth byte waits
      do_reset();
      rdy_mode = 1;
      foreach (mk5[i]) send(mk5[i]);
      cycles(40);
      chk("t3_acks_full", 32'(acks), 32'd4);
      chk("t3_src_left", 32'(src_q.size()), 32'd1);
      chk("t3_ev_valid", 32'(ev_valid), 32'd1);
      chk("t3_no_pops", 32'(log_q.size()), 32'd0);
      drain(100);
      chk("t3_acks", 32'(acks), 32'd5);
      chk("t3_events", 32'(log_q.size()), 32'd5);
      if (log_q.size() == 5)
         foreach (mk5[i]) chk("t3_order", 32'(log_q[i]), 32'(mk5[i]));

      // overflow blocks fetch, flag is sticky
      do_reset();
      ps2_overflow = 1'b1;
      send(8'h1C);
      cycles(10);
      chk("t4_no_ack", 32'(acks), 32'd0);
      chk("t4_ovf_seen", 32'(ovf_seen), 32'd1);
      ps2_overflow = 1'b0;
      cycles(3);
      chk("t4_ovf_sticky", 32'(ovf_seen), 32'd1);
      drain(100);
      chk("t4_acks_resume", 32'(acks), 32'd1);
      chk("t4_events", 32'(log_q.size()), 32'd1);

      // typematic repeats
      do_reset();
      send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
      drain(100);
      chk("t5_events", 32'(log_q.size()), FILTER_EN ? 32'd2 : 32'd4);
      chk("t5_key_count", 32'(key_count), FILTER_EN ? 32'd1 : 32'd3);

      // key_count wrap after 256 makes
      do_reset();
      for (int i = 0; i < 256; i++) send((i % 2 == 0) ? 8'h1C : 8'h1B);
      drain(2000);
      chk("t6_wrap", 32'(key_count), 32'd0);

      // reset landing on the ACK cycle of 2D
      do_reset();
      for (int i = 0; i < 255; i++) send((i % 2 == 0) ? 8'h1C : 8'h1B);
      drain(2000);
      chk("t7_count255", 32'(key_count), 32'd255);
      send(8'h2D);
      found = 1'b0;
      for (int i = 0; i < 50; i++) begin
         cycles(1);
         if (!ps2_nextdata_n) begin found = 1'b1; break; end
      end
      chk("t7_ack_seen", 32'(found), 32'd1);
      clr = 1'b1;
      cycles(1);
      clr = 1'b0;
      chk_reset_outputs("t7_clr");
      cycles(4);
      chk("t7_no_replay", 32'(ev_valid), 32'd0);
      log_q.delete();
      send(8'h1C);
      drain(100);
      chk("t7_key_count", 32'(key_count), 32'd1);

      // random traffic with random consumer and overflow pulses
      do_reset();
      for (int k = 0; k < 30; k++) begin
         rdy_mode = 2;
         for (int j = 0; j < 10; j++) send(tbl[$urandom_range(0, 7)]);
         cycles($urandom_range(0, 20));
         if ($urandom_range(0, 3) == 0) begin
            ps2_overflow = 1'b1;
            cycles($urandom_range(1, 8));
            ps2_overflow = 1'b0;
         end
         if ($urandom_range(0, 4) == 0) begin
            rdy_mode = 1;
            cycles($urandom_range(5, 25));
            rdy_mode = 2;
         end
      end
      drain(3000);
      chk("rand_src_empty", 32'(src_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
